// File: rtl/hamming_secded_stream.sv
// Pipelined Hamming SECDED encoder/decoder with valid/ready on both sides.
// Codeword layout is {g, p[P-1:0], d[DATA_W-1:0]}. Data bit i sits at the
// i-th non-power-of-two Hamming position. modo selects encode (0) or decode (1)
// for each word, and the mode travels with its word through both stages.
module hamming_secded_stream #(
  parameter  int DATA_W = 11,
  parameter  int CNT_W  = 16,
  localparam int P      = (DATA_W <= 4) ? 3 : (DATA_W <= 11) ? 4 : (DATA_W <= 26) ? 5 : 6,
  localparam int CODE_W = DATA_W + P + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              modo,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] entrada,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] saida,
  output logic [1:0]        status,
  input  logic              clear_cnt,
  output logic [CNT_W-1:0]  cnt_corrigidos,
  output logic [CNT_W-1:0]  cnt_duplos
);

  typedef enum logic [1:0] {
    ST_CLEAN   = 2'b00,
    ST_CORR    = 2'b01,
    ST_UNCORR  = 2'b10
  } status_e;

  // Hamming position of every data bit, packed P bits per entry.
  function automatic logic [DATA_W*P-1:0] calc_pos();
    logic [DATA_W*P-1:0] tbl;
    int                  k;
    tbl = '0;
    k   = 0;
    for (int pos = 1; pos < (1 << P); pos++) begin
      if (((pos & (pos - 1)) != 0) && (k < DATA_W)) begin
        tbl[k*P +: P] = P'(pos);
        k++;
      end
    end
    return tbl;
  endfunction

  // One bit per syndrome value: set when the syndrome names a real position.
  // Shortened codes leave the top syndromes unused; those mean "uncorrectable".
  function automatic logic [(1<<P)-1:0] calc_ok();
    logic [(1<<P)-1:0] ok;
    for (int s = 0; s < (1 << P); s++) begin
      ok[s] = (s <= DATA_W + P);
    end
    return ok;
  endfunction

  localparam logic [DATA_W*P-1:0]   POS_TBL = calc_pos();
  localparam logic [(1<<P)-1:0]     POS_OK  = calc_ok();

  // Handshake / stage control
  logic w_s2_adv;
  logic w_s1_load;
  logic w_handoff;

  // Stage 1 inputs
  logic [DATA_W-1:0] w_in_data;
  logic [P-1:0]      w_in_par;
  logic [P-1:0]      w_p_calc;
  logic [P-1:0]      w_syn;
  logic              w_chk;

  // Stage 1 registers
  logic              r_s1_valid;
  logic              r_s1_mode;
  logic [DATA_W-1:0] r_s1_data;
  logic [P-1:0]      r_s1_syn;
  logic              r_s1_chk;

  // Stage 2 next values and registers
  logic [DATA_W-1:0] w_fixed;
  status_e           w_dec_status;
  logic [CODE_W-1:0] w_s2_saida;
  status_e           w_s2_status;
  logic              r_s2_valid;
  logic [CODE_W-1:0] r_s2_saida;
  status_e           r_s2_status;

  logic [CNT_W-1:0]  r_cnt_corr;
  logic [CNT_W-1:0]  r_cnt_dup;

  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_adv;
  assign w_handoff = r_s2_valid && out_ready;
  assign in_ready  = rst_n && w_s1_load;

  assign w_in_data = entrada[DATA_W-1:0];
  assign w_in_par  = entrada[DATA_W +: P];

  // Recompute parity bits from the incoming data field.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_p_calc = '0;
    for (int j = 0; j < P; j++) begin
      for (int i = 0; i < DATA_W; i++) begin
        if (POS_TBL[i*P + j]) begin
          w_p_calc[j] = w_p_calc[j] ^ w_in_data[i];
        end
      end
    end
  end

  // Encode: syndrome register carries the parity bits and chk carries g.
  // Decode: syndrome against received parity, chk is the overall check.
  assign w_syn = w_p_calc ^ (modo ? w_in_par : '0);
  assign w_chk = modo ? (^entrada) : ((^w_in_data) ^ (^w_p_calc));

  // Stage 1 register: word, mode, syndrome and overall check.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset along with the valids so the output reads 0 right after reset.
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= 1'b0;
      r_s1_data  <= '0;
      r_s1_syn   <= '0;
      r_s1_chk   <= 1'b0;
    end else if (w_s1_load) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_mode <= modo;
        r_s1_data <= w_in_data;
        r_s1_syn  <= w_syn;
        r_s1_chk  <= w_chk;
      end
    end
  end

  // Classify the syndrome, correct a single data error and form the result.
  always_comb begin
    w_fixed      = r_s1_data;
    w_dec_status = ST_CLEAN;
    w_s2_saida   = '0;
    w_s2_status  = ST_CLEAN;
    if (r_s1_chk) begin
      if (POS_OK[r_s1_syn]) begin
        w_dec_status = ST_CORR;
        for (int i = 0; i < DATA_W; i++) begin
          if (r_s1_syn == POS_TBL[i*P +: P]) begin
            w_fixed[i] = ~r_s1_data[i];
          end
        end
      end else begin
        w_dec_status = ST_UNCORR;
      end
    end else if (r_s1_syn != '0) begin
      w_dec_status = ST_UNCORR;
    end
    if (r_s1_mode) begin
      w_s2_saida[DATA_W-1:0] = w_fixed;
      w_s2_status            = w_dec_status;
    end else begin
      w_s2_saida = {r_s1_chk, r_s1_syn, r_s1_data};
    end
  end

  // Stage 2 register: result held stable until downstream takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_saida  <= '0;
      r_s2_status <= ST_CLEAN;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_saida  <= w_s2_saida;
        r_s2_status <= w_s2_status;
      end
    end
  end

  // Saturating error counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_cnt) begin
      r_cnt_corr <= '0;
      r_cnt_dup  <= '0;
    end else if (w_handoff) begin
      if ((r_s2_status == ST_CORR) && (r_cnt_corr != {CNT_W{1'b1}})) begin
        r_cnt_corr <= r_cnt_corr + CNT_W'(1);
      end
      if ((r_s2_status == ST_UNCORR) && (r_cnt_dup != {CNT_W{1'b1}})) begin
        r_cnt_dup <= r_cnt_dup + CNT_W'(1);
      end
    end
  end

  assign out_valid      = r_s2_valid;
  assign saida          = r_s2_saida;
  assign status         = r_s2_status;
  assign cnt_corrigidos = r_cnt_corr;
  assign cnt_duplos     = r_cnt_dup;

endmodule

// File: tb/tb_hamming_secded_stream.sv
// Self-checking bench for hamming_secded_stream. Three instances (DATA_W 11,
// 4 and 26) share one scoreboard/monitor; expected results come from a
// textbook position-indexed Hamming model or from fixed known codewords.
module tb_hamming_secded_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        in_valid_x  [3];
  logic        modo_x      [3];
  logic        out_ready_x [3];
  logic        clear_x     [3];
  logic [63:0] entrada_x   [3];
  logic        in_ready_x  [3];
  logic        out_valid_x [3];
  logic [1:0]  status_x    [3];
  logic [63:0] saida_x     [3];
  logic [15:0] corr_x      [3];
  logic [15:0] dup_x       [3];

  logic [15:0] saida0;
  logic [7:0]  saida1;
  logic [31:0] saida2;
  logic [3:0]  corr1;
  logic [3:0]  dup1;

  assign saida_x[0] = 64'(saida0);
  assign saida_x[1] = 64'(saida1);
  assign saida_x[2] = 64'(saida2);
  assign corr_x[1]  = 16'(corr1);
  assign dup_x[1]   = 16'(dup1);

  hamming_secded_stream #(.DATA_W(11), .CNT_W(16)) u_w11 (
    .clk(clk), .rst_n(rst_n), .modo(modo_x[0]), .in_valid(in_valid_x[0]),
    .in_ready(in_ready_x[0]), .entrada(entrada_x[0][15:0]), .out_valid(out_valid_x[0]),
    .out_ready(out_ready_x[0]), .saida(saida0), .status(status_x[0]),
    .clear_cnt(clear_x[0]), .cnt_corrigidos(corr_x[0]), .cnt_duplos(dup_x[0])
  );

  hamming_secded_stream #(.DATA_W(4), .CNT_W(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .modo(modo_x[1]), .in_valid(in_valid_x[1]),
    .in_ready(in_ready_x[1]), .entrada(entrada_x[1][7:0]), .out_valid(out_valid_x[1]),
    .out_ready(out_ready_x[1]), .saida(saida1), .status(status_x[1]),
    .clear_cnt(clear_x[1]), .cnt_corrigidos(corr1), .cnt_duplos(dup1)
  );

  hamming_secded_stream #(.DATA_W(26), .CNT_W(16)) u_w26 (
    .clk(clk), .rst_n(rst_n), .modo(modo_x[2]), .in_valid(in_valid_x[2]),
    .in_ready(in_ready_x[2]), .entrada(entrada_x[2][31:0]), .out_valid(out_valid_x[2]),
    .out_ready(out_ready_x[2]), .saida(saida2), .status(status_x[2]),
    .clear_cnt(clear_x[2]), .cnt_corrigidos(corr_x[2]), .cnt_duplos(dup_x[2])
  );

  int dw_x   [3] = '{11, 4, 26};
  int cmax_x [3] = '{65535, 15, 65535};

  int          n_checks = 0;
  int          n_errors = 0;
  bit          chk_en   = 1'b0;
  int          occ        [3];
  int          mc_corr    [3];
  int          mc_dup     [3];
  bit          hold_prev  [3];
  logic [63:0] prev_saida [3];
  logic [1:0]  prev_status[3];
  logic [65:0] exp_q [3][$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_pow2(int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

  function automatic int m_p(int dw);
    int p = 1;
    while ((1 << p) < dw + p + 1) p++;
    return p;
  endfunction

  function automatic logic [63:0] m_mask(int w);
    logic [63:0] m = '0;
    for (int i = 0; i < w; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Textbook encode: lay data out on positions 1..n, parity j covers positions with bit j set.
  function automatic logic [63:0] m_encode(int dw, logic [63:0] d);
    int          p, n, k;
    logic        v [64];
    logic [63:0] cw;
    logic        par;
    p  = m_p(dw);
    n  = dw + p;
    k  = 0;
    cw = '0;
    for (int pos = 0; pos < 64; pos++) v[pos] = 1'b0;
    for (int pos = 1; pos <= n; pos++) begin
      if (!is_pow2(pos)) begin
        v[pos] = d[k];
        k++;
      end
    end
    for (int j = 0; j < p; j++) begin
      par = 1'b0;
      for (int pos = 1; pos <= n; pos++) begin
        if (((pos >> j) & 1) == 1) par = par ^ v[pos];
      end
      cw[dw + j] = par;
    end
    for (int i = 0; i < dw; i++) cw[i] = d[i];
    cw[dw + p] = ^cw;
    return cw;
  endfunction

  // Textbook decode: syndrome is the XOR of the positions of all set bits.
  function automatic void m_decode(input int dw, input logic [63:0] cw,
                                   output logic [63:0] data, output logic [1:0] st);
    int   p, n, k, jp, s, idx [64];
    logic c, b;
    p  = m_p(dw);
    n  = dw + p;
    k  = 0;
    jp = 0;
    s  = 0;
    c  = 1'b0;
    data = cw & m_mask(dw);
    for (int i = 0; i <= n; i++) c = c ^ cw[i];
    for (int pos = 0; pos < 64; pos++) idx[pos] = -1;
    for (int pos = 1; pos <= n; pos++) begin
      if (is_pow2(pos)) begin
        b = cw[dw + jp];
        jp++;
      end else begin
        b = cw[k];
        idx[pos] = k;
        k++;
      end
      if (b) s = s ^ pos;
    end
    if (!c && s == 0)      st = 2'b00;
    else if (c && s == 0)  st = 2'b01;
    else if (c && s <= n) begin
      st = 2'b01;
      if (!is_pow2(s)) data[idx[s]] = ~data[idx[s]];
    end else               st = 2'b10;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic mode, input logic [63:0] word,
                      input logic [63:0] es, input logic [1:0] est);
    bit ok = 1'b0;
    in_valid_x[k] = 1'b1;
    modo_x[k]     = mode;
    entrada_x[k]  = word;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (in_ready_x[k]) begin
        exp_q[k].push_back({es, est});
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid_x[k] = 1'b0;
  endtask

  task automatic wait_drain(input int k);
    bit done = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (exp_q[k].size() == 0) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    if (!done) check("drain_timeout", 64'(exp_q[k].size()), 64'd0);
  endtask

  task automatic send_random(input int k);
    int          dw, cwid, nflip, b0, b1;
    logic [63:0] d, cw, w, ed;
    logic [1:0]  est;
    dw   = dw_x[k];
    cwid = dw + m_p(dw) + 1;
    if ($urandom_range(0, 1) == 0) begin
      w = {$urandom, $urandom} & m_mask(cwid);
      send(k, 1'b0, w, m_encode(dw, w & m_mask(dw)), 2'b00);
    end else begin
      d     = {$urandom, $urandom} & m_mask(dw);
      cw    = m_encode(dw, d);
      nflip = $urandom_range(0, 2);
      b0    = $urandom_range(0, cwid - 1);
      b1    = (b0 + 1 + $urandom_range(0, cwid - 2)) % cwid;
      w     = cw;
      if (nflip >= 1) w[b0] = ~w[b0];
      if (nflip == 2) w[b1] = ~w[b1];
      m_decode(dw, w, ed, est);
      send(k, 1'b1, w, ed, est);
    end
  endtask

  task automatic sweep(input int k, input int nwords);
    int          dw, cwid;
    logic [63:0] d, cw, flip;
    dw   = dw_x[k];
    cwid = dw + m_p(dw) + 1;
    for (int w = 0; w < nwords; w++) begin
      d  = (k == 1) ? 64'(w) : ({$urandom, $urandom} & m_mask(dw));
      cw = m_encode(dw, d);
      send(k, 1'b0, d, cw, 2'b00);
      for (int b = 0; b < cwid; b++) begin
        flip    = '0;
        flip[b] = 1'b1;
        send(k, 1'b1, cw ^ flip, d, 2'b01);
      end
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic        hand, acc, er;
    logic [65:0] e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < 3; k++) begin
          er = rst_n && !(occ[k] == 2 && !out_ready_x[k]);
          check($sformatf("in_ready%0d", k), 64'(in_ready_x[k]), 64'(er));
          check($sformatf("cnt_corr%0d", k), 64'(corr_x[k]), 64'(mc_corr[k]));
          check($sformatf("cnt_dup%0d", k), 64'(dup_x[k]), 64'(mc_dup[k]));
          if (!rst_n) begin
            occ[k]       = 0;
            mc_corr[k]   = 0;
            mc_dup[k]    = 0;
            hold_prev[k] = 1'b0;
            exp_q[k].delete();
          end else begin
            if (hold_prev[k]) begin
              check($sformatf("hold_valid%0d", k), 64'(out_valid_x[k]), 64'd1);
              check($sformatf("hold_saida%0d", k), saida_x[k], prev_saida[k]);
              check($sformatf("hold_status%0d", k), 64'(status_x[k]), 64'(prev_status[k]));
            end
            hand = out_valid_x[k] && out_ready_x[k];
            acc  = in_valid_x[k] && in_ready_x[k];
            if (hand) begin
              if (exp_q[k].size() == 0) begin
                check($sformatf("spurious_out%0d", k), 64'd1, 64'd0);
              end else begin
                e = exp_q[k].pop_front();
                check($sformatf("saida%0d", k), saida_x[k], e[65:2]);
                check($sformatf("status%0d", k), 64'(status_x[k]), 64'(e[1:0]));
                if (e[1:0] == 2'b01 && mc_corr[k] < cmax_x[k]) mc_corr[k]++;
                if (e[1:0] == 2'b10 && mc_dup[k]  < cmax_x[k]) mc_dup[k]++;
              end
            end
            if (clear_x[k]) begin
              mc_corr[k] = 0;
              mc_dup[k]  = 0;
            end
            occ[k]         = occ[k] + int'(acc) - int'(hand);
            hold_prev[k]   = out_valid_x[k] && !out_ready_x[k];
            prev_saida[k]  = saida_x[k];
            prev_status[k] = status_x[k];
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    bit bp_done;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid_x[k]  = 1'b0;
      modo_x[k]      = 1'b0;
      out_ready_x[k] = 1'b1;
      clear_x[k]     = 1'b0;
      entrada_x[k]   = '0;
      occ[k]         = 0;
      mc_corr[k]     = 0;
      mc_dup[k]      = 0;
      hold_prev[k]   = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("ready_in_reset", 64'(in_ready_x[0]), 64'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid_x[0]), 64'd0);
    check("rst_saida", saida_x[0], 64'd0);
    check("rst_status", 64'(status_x[0]), 64'd0);
    check("rst_ready", 64'(in_ready_x[0]), 64'd1);
    tick();

    // Fixed encodes with latency check on the first one.
    send(0, 1'b0, 64'h0001, 64'h9801, 2'b00);
    @(negedge clk);
    check("latency_n1", 64'(out_valid_x[0]), 64'd0);
    @(negedge clk);
    check("latency_n2", 64'(out_valid_x[0]), 64'd1);
    tick();
    send(0, 1'b0, 64'h07FF, 64'hFFFF, 2'b00);
    send(0, 1'b0, 64'h0000, 64'h0000, 2'b00);
    send(0, 1'b0, 64'hF801, 64'h9801, 2'b00);
    send(0, 1'b1, 64'h9800, 64'h0001, 2'b01);
    wait_drain(0);
    check("corr_after_first", 64'(corr_x[0]), 64'd1);

    // Single errors in g and p0, a clean word, then a double error.
    send(0, 1'b1, 64'h1801, 64'h0001, 2'b01);
    send(0, 1'b1, 64'h9001, 64'h0001, 2'b01);
    send(0, 1'b1, 64'h9801, 64'h0001, 2'b00);
    send(0, 1'b1, 64'h9802, 64'h0002, 2'b10);
    wait_drain(0);
    check("corr_total", 64'(corr_x[0]), 64'd3);
    check("dup_total", 64'(dup_x[0]), 64'd1);

    // clear_cnt in the same cycle as a status-01 handoff.
    send(0, 1'b1, 64'h9800, 64'h0001, 2'b01);
    @(posedge clk);
    #1;
    clear_x[0] = 1'b1;
    tick();
    clear_x[0] = 1'b0;
    wait_drain(0);
    check("clear_priority", 64'(corr_x[0]), 64'd0);

    // Random mixed traffic under periodic backpressure.
    bp_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) send_random(0);
        bp_done = 1'b1;
      end
      begin
        int ph = 0;
        while (!bp_done) begin
          @(posedge clk);
          #1;
          out_ready_x[0] = (ph % 3 == 0);
          ph++;
        end
      end
    join
    out_ready_x[0] = 1'b1;
    wait_drain(0);

    // Reset with two words in flight: nothing may emerge afterwards.
    out_ready_x[0] = 1'b0;
    send_random(0);
    send_random(0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    out_ready_x[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("quiet_after_reset", 64'(out_valid_x[0]), 64'd0);
    end
    tick();

    // Encode -> flip each bit -> decode sweeps.
    fork
      sweep(0, 12);
      sweep(1, 16);
      sweep(2, 6);
    join
    for (int k = 0; k < 3; k++) wait_drain(k);
    check("w4_cnt_saturated", 64'(corr_x[1]), 64'd15);
    check("w4_dup_zero", 64'(dup_x[1]), 64'd0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("leftover%0d", k), 64'(exp_q[k].size()), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hamming_secded_stream.md
# hamming_secded_stream

Parametrised, pipelined Hamming SECDED encoder/decoder with valid/ready streaming on both sides. It is the next generation of the team's fixed 11-bit Hamming(15,11) parity generator and generalises it in three ways:
- arbitrary data width;
- an extra overall-parity bit for double-error detection;
- a runtime encode/decode mode with single-error correction and saturating error counters.

It sits between a data source and a storage or link stage and processes one word per cycle.

## Interface
Parameters:
- DATA_W, 11: data bits per word; legal range 4..57.
- P, derived: smallest integer with 2^P >= DATA_W+P+1; 4 for DATA_W=11.
- CODE_W, derived: DATA_W+P+1; 16 for DATA_W=11.
- CNT_W, 16: width of each error counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- modo  in  1  0 = encode, 1 = decode; sampled with each accepted input word.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts the word this cycle.
- entrada  in  CODE_W  encode uses [DATA_W-1:0] and ignores upper bits; decode uses the full received codeword.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- saida  out  CODE_W  encode: codeword; decode: corrected data in [DATA_W-1:0], upper bits 0.
- status  out  2  00 clean, 01 single error corrected, 10 uncorrectable; always 00 in encode.
- clear_cnt  in  1  synchronous clear of both counters.
- cnt_corrigidos  out  CNT_W  count of status-01 results delivered.
- cnt_duplos  out  CNT_W  count of status-10 results delivered.

## Operation
- Codeword layout: {g, p[P-1:0], d[DATA_W-1:0]}.
- Hamming positions: data bit i occupies the i-th non-power-of-two position in 1..DATA_W+P, in ascending order (d0→3, d1→5, d2→6, d3→7, d4→9, ...).
- Parity p[j] is the XOR of all data bits whose position has bit j set.
- g is the XOR of all data bits and all P parity bits (even overall parity).
- Encode: saida = codeword, status = 00.
- Decode:
  - Syndrome s = recomputed p XOR received p.
  - Overall check c = XOR of all CODE_W received bits.
  - c=0, s=0: clean, status 00.
  - c=1, s=0: error in g, status 01.
  - c=1, s a power of two: parity-bit error, status 01, data unchanged.
  - c=1, s a data position: flip that data bit, status 01.
  - c=1, s > DATA_W+P (shortened code): status 10, data passed uncorrected.
  - c=0, s≠0: double error, status 10, data passed uncorrected.
- Counters:
  - Each counter increments when a result with the matching status is handed off (out_valid && out_ready).
  - Counters saturate at 2^CNT_W-1.
  - clear_cnt has priority over a same-cycle increment; the counters read 0 afterwards.
- Mode travels down the pipeline with its word. Mixed encode/decode traffic is legal back-to-back.

## Timing
- Two register stages:
  - S1 registers the word, mode, s and c.
  - S2 registers saida and status.
- Latency: a word accepted in cycle n has out_valid high in cycle n+2 when there is no backpressure.
- Throughput: 1 word per cycle while out_ready=1.
- Stage advance rule: a stage loads when it is empty or its contents are leaving this cycle.
- in_ready = !S1_valid || S1 advances. in_ready is combinational from out_ready; there is no combinational path from in_valid to in_ready.
- Under backpressure (out_ready=0): saida, status and out_valid hold stable. Up to 2 words are buffered, then in_ready drops. No word is lost or duplicated.
- Reset (rst_n=0 at a clock edge), including mid-stream:
  - In-flight words are discarded.
  - out_valid=0, saida=0, status=00, both counters=0.
  - in_ready=0 while rst_n is low, and 1 in the first cycle after release.
- Handshake sampling: in_valid, entrada, modo, out_ready and clear_cnt are sampled only on rising clk.

## Test plan
All scenarios use DATA_W=11 unless stated.
- Reset and fixed encodes:
  - Reset → out_valid=0, saida=0, counters=0.
  - Encode 0x001 → saida 0x9801, status 00, out_valid 2 cycles after acceptance.
  - Encode 0x7FF → 0xFFFF; encode 0x000 → 0x0000.
- Single-error decode:
  - Decode 0x9800 (d0 flipped) → saida 0x0001, status 01, cnt_corrigidos=1.
  - Decode 0x1801 (g flipped) → 0x0001, status 01.
  - Decode 0x9001 (p0 flipped) → 0x0001, status 01.
- Double-error decode: 0x9802 → status 10, saida 0x0002 uncorrected, cnt_duplos=1.
- Backpressure: stream 8 random encode/decode words with out_ready toggling 1,0,0,1,... → output order and values match a reference model, no drops, in_ready=0 exactly when both stages are full and held.
- Counters:
  - Preload the counter to the saturation value with CNT_W=4 → it holds at 15.
  - Pulse clear_cnt in the same cycle as a status-01 handoff → cnt_corrigidos=0.
- Reset and sweep:
  - Assert rst_n=0 with 2 words in flight → nothing emerges after release.
  - Exhaustive encode→flip-each-bit→decode sweep for DATA_W=4, 11 and 26 → every single-bit flip gives status 01 with correct data.
